instr_prefetch_queue: RTL and testbench

INSTR_PREFETCH_QUEUE -- requirements
Module: instr_prefetch_queue

---
 rtl/instr_prefetch_queue.sv | 132 +++++++++++++
 tb/tb_instr_prefetch_queue.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch_queue.sv
// Halfword instruction prefetch queue fed by a two-bank (even/odd) ROM, one word per request.
// Optional build macro PREFETCH_STALL_CNT_EN adds a 32-bit counter of cycles with nothing to issue.
module instr_prefetch_queue #(
  parameter int ADDR_W = 14,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              rom_req,
  output logic [ADDR_W-2:0] rom_addr,
  input  logic [31:0]       rom_data,
  output logic [15:0]       ir_0,
  output logic [15:0]       ir_1,
  output logic [1:0]        ir_cnt,
  output logic [ADDR_W-1:0] ir_0_addr,
  input  logic [1:0]        deq_cnt
`ifdef PREFETCH_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [15:0]       mem_q [DEPTH];
  logic [15:0]       mem_d [DEPTH];
  logic [PW-1:0]     rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [ADDR_W-2:0] fetch_q, fetch_d;
  logic [ADDR_W-1:0] ir0_addr_q, ir0_addr_d;
  logic              drop_even_q, drop_even_d;
  logic              inflight_q, inflight_d;
  logic [CW:0]       need;
  logic [1:0]        deq_eff;
  logic [1:0]        push_n;

  // Reserve room for the response already in flight plus the one about to be requested.
  always_comb begin
    need    = {1'b0, count_q} + (inflight_q ? (CW+1)'(2) : (CW+1)'(0)) + (CW+1)'(2);
    rom_req = !rst && !redirect_valid && (need <= (CW+1)'(DEPTH));
  end

  always_comb begin
    if (rst)                     ir_cnt = 2'd0;
    else if (count_q >= CW'(2))  ir_cnt = 2'd2;
    else                         ir_cnt = count_q[1:0];
    ir_0      = (ir_cnt != 2'd0) ? mem_q[rd_q] : 16'h0;
    ir_1      = (ir_cnt == 2'd2) ? mem_q[rd_q + PW'(1)] : 16'h0;
    ir_0_addr = ir0_addr_q;
    rom_addr  = fetch_q;
    deq_eff   = (deq_cnt > ir_cnt) ? ir_cnt : deq_cnt;
  end

  always_comb begin
    mem_d       = mem_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    count_d     = count_q;
    fetch_d     = fetch_q;
    ir0_addr_d  = ir0_addr_q;
    drop_even_d = drop_even_q;
    inflight_d  = rom_req;
    push_n      = 2'd0;
    if (redirect_valid) begin
      rd_d        = '0;
      wr_d        = '0;
      count_d     = '0;
      fetch_d     = redirect_addr[ADDR_W-1:1];
      ir0_addr_d  = redirect_addr;
      drop_even_d = redirect_addr[0];
      inflight_d  = 1'b0;
    end else begin
      if (rom_req) fetch_d = fetch_q + 1'b1;
      if (inflight_q) begin
        if (drop_even_q) begin
          mem_d[wr_q] = rom_data[31:16];
          push_n      = 2'd1;
          drop_even_d = 1'b0;
        end else begin
          mem_d[wr_q]           = rom_data[15:0];
          mem_d[wr_q + PW'(1)]  = rom_data[31:16];
          push_n                = 2'd2;
        end
      end
      wr_d       = wr_q + PW'(push_n);
      rd_d       = rd_q + PW'(deq_eff);
      ir0_addr_d = ir0_addr_q + ADDR_W'(deq_eff);
      count_d    = count_q + CW'(push_n) - CW'(deq_eff);
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      rd_q        <= '0;
      wr_q        <= '0;
      count_q     <= '0;
      fetch_q     <= '0;
      ir0_addr_q  <= '0;
      drop_even_q <= 1'b0;
      inflight_q  <= 1'b0;
    end else begin
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      count_q     <= count_d;
      fetch_q     <= fetch_d;
      ir0_addr_q  <= ir0_addr_d;
      drop_even_q <= drop_even_d;
      inflight_q  <= inflight_d;
    end
  end

`ifdef PREFETCH_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (ir_cnt == 2'd0 && !redirect_valid) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed bench for instr_prefetch_queue with a behavioural two-bank ROM.
// Define PREFETCH_STALL_CNT_EN to also exercise the stall counter.
module tb_instr_prefetch_queue;

  localparam int ADDR_W = 14;
  localparam int DEPTH  = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              redirect_valid = 1'b0;
  logic [ADDR_W-1:0] redirect_addr = '0;
  logic              rom_req;
  logic [ADDR_W-2:0] rom_addr;
  logic [31:0]       rom_data = 32'h0;
  logic [15:0]       ir_0, ir_1;
  logic [1:0]        ir_cnt;
  logic [ADDR_W-1:0] ir_0_addr;
  logic [1:0]        deq_cnt = 2'd0;
`ifdef PREFETCH_STALL_CNT_EN
  logic [31:0]       stall_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;
  int req_cnt = 0;
  int req_base;
  int exp_h;
  int n;

  instr_prefetch_queue #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .rom_req(rom_req), .rom_addr(rom_addr), .rom_data(rom_data),
    .ir_0(ir_0), .ir_1(ir_1), .ir_cnt(ir_cnt), .ir_0_addr(ir_0_addr),
    .deq_cnt(deq_cnt)
`ifdef PREFETCH_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Halfword h of the ROM image; word 0 is {BF00, A001}.
  function automatic logic [15:0] hw(input int h);
    logic [15:0] r;
    if (h == 0)      r = 16'hA001;
    else if (h == 1) r = 16'hBF00;
    else             r = 16'h1000 + 16'(h);
    return r;
  endfunction

  always @(posedge clk) begin
    if (rom_req) begin
      rom_data <= {hw(2 * int'(rom_addr) + 1), hw(2 * int'(rom_addr))};
      req_cnt  <= req_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset and first fetch
    step();
    step();
    #1;
    chk("rst_rom_req", 32'(rom_req), 0);
    chk("rst_ir_cnt",  32'(ir_cnt), 0);
    chk("rst_ir_0",    32'(ir_0), 0);
    chk("rst_ir_1",    32'(ir_1), 0);
    chk("rst_ir0_addr", 32'(ir_0_addr), 0);
    rst = 1'b0;
    #1;
    chk("c1_rom_req",  32'(rom_req), 1);
    chk("c1_rom_addr", 32'(rom_addr), 0);
    req_base = req_cnt;
    step();
    step();
    #1;
    chk("c3_ir_cnt",   32'(ir_cnt), 2);
    chk("c3_ir_0",     32'(ir_0), 32'hA001);
    chk("c3_ir_1",     32'(ir_1), 32'hBF00);
    chk("c3_ir0_addr", 32'(ir_0_addr), 0);

    // fill with no consumption
    repeat (8) step();
    #1;
    chk("full_rom_req", 32'(rom_req), 0);
    chk("full_nreq",    32'(req_cnt - req_base), 4);
    chk("full_ir_0",    32'(ir_0), 32'hA001);
    chk("full_ir_1",    32'(ir_1), 32'hBF00);

    // drain and keep streaming, wrapping the buffer several times
    exp_h   = 0;
    deq_cnt = 2'd2;
    for (int c = 0; c < 60 && exp_h < 40; c++) begin
      n = int'(ir_cnt);
      if (n >= 1) begin
        chk("strm_ir_0",  32'(ir_0), 32'(hw(exp_h)));
        chk("strm_addr",  32'(ir_0_addr), 32'(exp_h));
      end
      if (n == 2) chk("strm_ir_1", 32'(ir_1), 32'(hw(exp_h + 1)));
      exp_h += n;
      step();
      #1;
    end
    chk("strm_len_ok", 32'(exp_h >= 40), 1);

    // redirect to odd address 5 with a request in flight
    chk("pre_redir_req", 32'(rom_req), 1);
    redirect_valid = 1'b1;
    redirect_addr  = 14'd5;
    #1;
    chk("redir_rom_req", 32'(rom_req), 0);
    step();
    redirect_valid = 1'b0;
    deq_cnt        = 2'd0;
    #1;
    chk("r1_rom_req",  32'(rom_req), 1);
    chk("r1_rom_addr", 32'(rom_addr), 2);
    chk("r1_ir_cnt",   32'(ir_cnt), 0);
    step();
    #1;
    chk("r2_ir_cnt",   32'(ir_cnt), 0);
    step();
    #1;
    chk("r3_ir_cnt",   32'(ir_cnt), 1);
    chk("r3_ir_0",     32'(ir_0), 32'(hw(5)));
    chk("r3_ir0_addr", 32'(ir_0_addr), 5);
    chk("r3_ir_1",     32'(ir_1), 0);

    // over-dequeue while only one halfword is valid
    deq_cnt = 2'd2;
    step();
    deq_cnt = 2'd0;
    #1;
    chk("ovd_ir_cnt",   32'(ir_cnt), 2);
    chk("ovd_ir_0",     32'(ir_0), 32'(hw(6)));
    chk("ovd_ir0_addr", 32'(ir_0_addr), 6);
    chk("ovd_ir_1",     32'(ir_1), 32'(hw(7)));

    // mid-operation reset
    rst = 1'b1;
    #1;
    chk("mrst_rom_req", 32'(rom_req), 0);
    chk("mrst_ir_cnt",  32'(ir_cnt), 0);
    chk("mrst_ir_0",    32'(ir_0), 0);
    step();
    rst = 1'b0;
    #1;
    chk("mrst1_rom_req",  32'(rom_req), 1);
    chk("mrst1_rom_addr", 32'(rom_addr), 0);
    chk("mrst1_ir_cnt",   32'(ir_cnt), 0);
    step();
    #1;
    chk("mrst2_ir_cnt", 32'(ir_cnt), 0);
    step();
    #1;
    chk("mrst3_ir_cnt",   32'(ir_cnt), 2);
    chk("mrst3_ir_0",     32'(ir_0), 32'hA001);
    chk("mrst3_ir0_addr", 32'(ir_0_addr), 0);

`ifdef PREFETCH_STALL_CNT_EN
    // one idle cycle, a redirect, then two more empty cycles
    rst = 1'b1;
    step();
    #1;
    chk("stall_rst", stall_cnt, 0);
    rst = 1'b0;
    step();
    redirect_valid = 1'b1;
    redirect_addr  = 14'd0;
    step();
    redirect_valid = 1'b0;
    step();
    step();
    #1;
    chk("stall_ir_cnt", 32'(ir_cnt), 2);
    chk("stall_cnt",    stall_cnt, 3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
